order_frame_tx: RTL and testbench



---
 rtl/order_frame_tx_if.sv | 22 ++
 rtl/order_frame_tx.sv | 130 +++++++++++++
 tb/tb_order_frame_tx.sv | 255 +++++++++++++++++++++++++
 3 files changed

// File: rtl/order_frame_tx_if.sv
// Byte-wide order frame stream with a valid/ready handshake.
// tx_last marks the sixth and final byte of each frame.
interface order_frame_tx_if;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;
  logic       tx_last;

  modport master (
    output tx_data,
    output tx_valid,
    output tx_last,
    input  tx_ready
  );

  modport slave (
    input  tx_data,
    input  tx_valid,
    input  tx_last,
    output tx_ready
  );
endinterface

// File: rtl/order_frame_tx.sv
// Queues buy/sell decisions and serialises each one as a 6-byte order frame.
// Frame: A5, side, seq, price hi, price lo, XOR of bytes 1..4.
module order_frame_tx #(
  parameter int data_width = 16,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  data_valid_in,
  input  logic                  buy_in,
  input  logic                  sell_in,
  input  logic [data_width-1:0] price_in,
  order_frame_tx_if.master      tx,
  output logic                  busy,
  output logic [7:0]            drop_count,
  output logic [7:0]            conflict_count
);

  localparam int AW = $clog2(FIFO_DEPTH);

  typedef struct packed {
    logic [7:0]  side;
    logic [15:0] price;
  } order_t;

  typedef enum logic {IDLE, SEND} state_t;

  order_t        mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;

  state_t     state;
  logic [2:0] byte_idx;
  logic [7:0] seq;
  logic [7:0] cur_seq;
  order_t     cur;

  logic   empty;
  logic   full;
  logic   conflict;
  logic   accept;
  logic   push;
  logic   hs;
  logic   pop;
  order_t in_order;

  assign empty    = (count == '0);
  assign full     = (count == (AW+1)'(FIFO_DEPTH));
  assign conflict = data_valid_in & buy_in & sell_in;
  assign accept   = data_valid_in & (buy_in ^ sell_in);
  assign push     = accept & ~full;
  assign hs       = tx.tx_valid & tx.tx_ready;
  assign in_order = {buy_in ? 8'h42 : 8'h53, 16'(price_in)};
  assign busy     = (state == SEND) | ~empty;

  // Pop happens exactly when a new frame is loaded into the frame register.
  assign pop = ~empty &
               ((state == IDLE) | (hs & (byte_idx == 3'd5)));

  function automatic logic [7:0] frame_byte(
    logic [2:0] idx,
    order_t     o,
    logic [7:0] s
  );
    logic [7:0] r;
    unique case (idx)
      3'd0:    r = 8'hA5;
      3'd1:    r = o.side;
      3'd2:    r = s;
      3'd3:    r = o.price[15:8];
      3'd4:    r = o.price[7:0];
      default: r = o.side ^ s ^ o.price[15:8] ^ o.price[7:0];
    endcase
    return r;
  endfunction

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= in_order;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr         <= '0;
      rd_ptr         <= '0;
      count          <= '0;
      state          <= IDLE;
      byte_idx       <= '0;
      seq            <= '0;
      cur_seq        <= '0;
      cur            <= '0;
      tx.tx_data     <= '0;
      tx.tx_valid    <= 1'b0;
      tx.tx_last     <= 1'b0;
      drop_count     <= '0;
      conflict_count <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count + (AW+1)'(push) - (AW+1)'(pop);

      if (accept & full & (drop_count != 8'hFF))
        drop_count <= drop_count + 8'd1;
      if (conflict & (conflict_count != 8'hFF))
        conflict_count <= conflict_count + 8'd1;

      if (pop) begin
        cur         <= mem[rd_ptr];
        cur_seq     <= seq;
        seq         <= seq + 8'd1;
        byte_idx    <= '0;
        state       <= SEND;
        tx.tx_data  <= 8'hA5;
        tx.tx_valid <= 1'b1;
        tx.tx_last  <= 1'b0;
      end else if ((state == SEND) & hs) begin
        if (byte_idx == 3'd5) begin
          state       <= IDLE;
          tx.tx_valid <= 1'b0;
          tx.tx_last  <= 1'b0;
        end else begin
          byte_idx   <= byte_idx + 3'd1;
          tx.tx_data <= frame_byte(byte_idx + 3'd1, cur, cur_seq);
          tx.tx_last <= (byte_idx == 3'd4);
        end
      end
    end
  end

endmodule

// File: tb/tb_order_frame_tx.sv
// Scoreboard bench for order_frame_tx: frames predicted from accepted orders,
// checked byte by byte by a monitor as the stream hands them off.
module tb_order_frame_tx;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        dv;
  logic        buy;
  logic        sell;
  logic [15:0] price;
  logic        busy;
  logic [7:0]  drop_count;
  logic [7:0]  conflict_count;

  order_frame_tx_if txi ();

  order_frame_tx #(
    .data_width(16),
    .FIFO_DEPTH(DEPTH)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .data_valid_in (dv),
    .buy_in        (buy),
    .sell_in       (sell),
    .price_in      (price),
    .tx            (txi),
    .busy          (busy),
    .drop_count    (drop_count),
    .conflict_count(conflict_count)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;
  logic [8:0] exp_q[$];
  int accepted = 0;
  int done = 0;
  int m_seq = 0;
  int m_drop = 0;
  int m_conf = 0;

  task automatic chk(string name, int act, int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic expect_frame(logic [7:0] side, logic [15:0] p);
    logic [7:0] b[6];
    b[0] = 8'hA5;
    b[1] = side;
    b[2] = 8'(m_seq);
    b[3] = p[15:8];
    b[4] = p[7:0];
    b[5] = b[1] ^ b[2] ^ b[3] ^ b[4];
    for (int i = 0; i < 6; i++) exp_q.push_back({i == 5, b[i]});
    m_seq = (m_seq + 1) % 256;
    accepted++;
  endtask

  // Called and returns just after a rising edge; the strobe covers one edge.
  task automatic strobe(bit v, bit b, bit s, logic [15:0] p, bit fits);
    dv = v; buy = b; sell = s; price = p;
    if (v && b && s) m_conf = (m_conf < 255) ? m_conf + 1 : 255;
    else if (v && (b ^ s)) begin
      if (fits) expect_frame(b ? 8'h42 : 8'h53, p);
      else m_drop = (m_drop < 255) ? m_drop + 1 : 255;
    end
    @(posedge clk); #1;
    dv = 0; buy = 0; sell = 0;
  endtask

  task automatic do_reset();
    txi.tx_ready = 1'b0;
    rst = 1'b1;
    exp_q.delete();
    accepted = 0; done = 0;
    m_seq = 0; m_drop = 0; m_conf = 0;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic wait_valid(string name, int maxc);
    int n = 0;
    while (!txi.tx_valid && n < maxc) begin
      @(posedge clk); #1;
      n++;
    end
    if (!txi.tx_valid) chk(name, 0, 1);
  endtask

  task automatic drain(string name);
    int n = 0;
    txi.tx_ready = 1'b1;
    while (done != accepted && n < 3000) begin
      @(posedge clk); #1;
      n++;
    end
    chk(name, done, accepted);
    chk({name, "_qempty"}, exp_q.size(), 0);
  endtask

  // Monitor: bytes are sampled mid-cycle, the handshake completes at the next edge.
  logic [7:0] pd;
  logic       pl;
  bit         stall_prev = 0;
  logic [8:0] e;

  always @(negedge clk) begin
    if (rst) stall_prev = 0;
    else begin
      if (stall_prev)
        chk("stall_hold", {txi.tx_valid, txi.tx_last, txi.tx_data}, {1'b1, pl, pd});
      if (txi.tx_valid && txi.tx_ready) begin
        if (exp_q.size() == 0) begin
          vectors++;
          miscompares++;
          $display("FAIL unexpected_byte: got %0h expected none", txi.tx_data);
        end else begin
          e = exp_q.pop_front();
          chk("tx_byte", {txi.tx_last, txi.tx_data}, e);
          if (e[8]) done++;
        end
      end
      stall_prev = txi.tx_valid && !txi.tx_ready;
      pd = txi.tx_data;
      pl = txi.tx_last;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int n;
    int kind;
    logic [15:0] p;
    rst = 1'b1; dv = 0; buy = 0; sell = 0; price = '0;
    txi.tx_ready = 1'b0;
    @(posedge clk); #1;
    do_reset();

    chk("rst_valid", txi.tx_valid, 0);
    chk("rst_last", txi.tx_last, 0);
    chk("rst_data", txi.tx_data, 0);
    chk("rst_busy", busy, 0);
    chk("rst_drop", drop_count, 0);
    chk("rst_conflict", conflict_count, 0);

    // Single buy: latency of two cycles, then busy falls with the last byte.
    txi.tx_ready = 1'b1;
    strobe(1, 1, 0, 16'h1234, 1);
    chk("lat_early", txi.tx_valid, 0);
    @(posedge clk); #1;
    chk("lat_valid", txi.tx_valid, 1);
    chk("lat_a5", txi.tx_data, 8'hA5);
    drain("buy1");
    chk("busy_after", busy, 0);
    chk("valid_after", txi.tx_valid, 0);

    // Back-to-back sell and buy: twelve consecutive valid bytes.
    strobe(1, 0, 1, 16'h00FF, 1);
    strobe(1, 1, 0, 16'h0100, 1);
    wait_valid("b2b_timeout", 10);
    n = 0;
    while (txi.tx_valid && n < 20) begin
      n++;
      @(posedge clk); #1;
    end
    chk("no_bubble", n, 12);
    drain("b2b");

    // Backpressure at byte 3 for five cycles.
    strobe(1, 1, 0, 16'hBEEF, 1);
    wait_valid("stall_timeout", 10);
    repeat (3) begin @(posedge clk); #1; end
    txi.tx_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      chk("stall_valid", txi.tx_valid, 1);
      chk("stall_msb", txi.tx_data, 8'hBE);
      @(posedge clk); #1;
    end
    drain("stall");

    // Six orders with the link stalled: frame register plus FIFO hold five.
    txi.tx_ready = 1'b0;
    for (int i = 0; i < 6; i++)
      strobe(1, 1, 0, 16'($urandom), i < DEPTH + 1);
    chk("drop_count", drop_count, m_drop);
    chk("busy_stalled", busy, 1);
    drain("overflow");

    // Conflict, neither, and buy without valid: no frame, seq untouched.
    strobe(1, 1, 1, 16'h5555, 1);
    strobe(1, 0, 0, 16'h6666, 1);
    strobe(0, 1, 0, 16'h7777, 1);
    chk("conflict_count", conflict_count, m_conf);
    repeat (2) begin @(posedge clk); #1; end
    chk("no_frame", txi.tx_valid, 0);
    strobe(1, 0, 1, 16'hCAFE, 1);
    drain("after_conflict");

    // Reset during byte 2 with two orders queued.
    txi.tx_ready = 1'b1;
    strobe(1, 1, 0, 16'h1111, 1);
    strobe(1, 1, 0, 16'h2222, 1);
    strobe(1, 0, 1, 16'h3333, 1);
    @(posedge clk); #1;
    do_reset();
    chk("mid_rst_valid", txi.tx_valid, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_drop", drop_count, 0);
    chk("mid_rst_conflict", conflict_count, 0);
    repeat (4) begin @(posedge clk); #1; end
    chk("no_resume", txi.tx_valid, 0);
    txi.tx_ready = 1'b1;
    strobe(1, 1, 0, 16'h0042, 1);
    drain("post_rst");

    // Random traffic with random backpressure, kept clear of FIFO overflow.
    for (int it = 0; it < 400; it++) begin
      txi.tx_ready = ($urandom_range(3) != 0);
      kind = $urandom_range(9);
      p = 16'($urandom);
      if (kind < 4 && (accepted - done) < DEPTH - 1)
        strobe(1, kind[0], ~kind[0], p, 1);
      else if (kind == 4) strobe(1, 1, 1, p, 1);
      else if (kind == 5) strobe(1, 0, 0, p, 1);
      else if (kind == 6) strobe(0, 1, 0, p, 1);
      else strobe(0, 0, 0, p, 1);
    end
    drain("random");
    chk("rand_drop", drop_count, m_drop);
    chk("rand_conflict", conflict_count, m_conf);

    // Conflict counter saturation.
    for (int i = 0; i < 260; i++) strobe(1, 1, 1, 16'h0, 1);
    chk("conflict_sat", conflict_count, m_conf);
    strobe(1, 1, 0, 16'hABCD, 1);
    drain("final");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
